// File: rtl/tile_dispatcher.sv
// tile_dispatcher
//   Triangle-level front end of the tile processor. Latches one screen-space
//   triangle, builds its bounding box in tile units clamped to the screen,
//   then issues one request per covered tile (row-major, x fastest) over a
//   valid/ready handshake. Fully off-screen triangles are culled without any
//   downstream traffic.
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   vld_in / rdy_in       triangle handshake from upstream
//   v0, v1, v2            vertices, signed fixed point
//   in_metadata           per-triangle metadata (tile_x/tile_y ignored)
//   vld_out / rdy_out     tile request handshake to tile_processor
//   out_v0..out_v2        latched vertices
//   out_metadata          latched metadata with tile_x/tile_y = current tile
//   tri_done, tri_culled  one-cycle completion / cull pulses
//   tile_count            tiles accepted downstream for current/last triangle

`ifndef FX_FRAC_BITS
`define FX_FRAC_BITS 4
`endif
`ifndef FX_TOTAL_BITS
`define FX_TOTAL_BITS 16
`endif
`ifndef TILE_COLUMNS_BITS
`define TILE_COLUMNS_BITS 5
`endif
`ifndef TILE_ROWS_BITS
`define TILE_ROWS_BITS 5
`endif

package tile_dispatcher_pkg;
  typedef struct packed {
    logic signed [`FX_TOTAL_BITS-1:0] x;
    logic signed [`FX_TOTAL_BITS-1:0] y;
    logic signed [`FX_TOTAL_BITS-1:0] z;
  } coord_3d_t;

  typedef struct packed {
    logic [15:0]                    tri_id;
    logic [`TILE_COLUMNS_BITS-1:0]  tile_x;
    logic [`TILE_ROWS_BITS-1:0]     tile_y;
  } metadata_t;
endpackage

module tile_dispatcher
  import tile_dispatcher_pkg::*;
#(
  parameter int TILE_SHIFT = 5,
  parameter int MAX_TILE_X = (1 << `TILE_COLUMNS_BITS) - 1,
  parameter int MAX_TILE_Y = (1 << `TILE_ROWS_BITS) - 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vld_in,
  output logic             rdy_in,
  input  coord_3d_t        v0,
  input  coord_3d_t        v1,
  input  coord_3d_t        v2,
  input  metadata_t        in_metadata,
  input  logic             rdy_out,
  output logic             vld_out,
  output coord_3d_t        out_v0,
  output coord_3d_t        out_v1,
  output coord_3d_t        out_v2,
  output metadata_t        out_metadata,
  output logic             tri_done,
  output logic             tri_culled,
  output logic [CNT_W-1:0] tile_count
);

  localparam int W      = `FX_TOTAL_BITS;
  localparam int CW     = `TILE_COLUMNS_BITS;
  localparam int RW     = `TILE_ROWS_BITS;
  localparam int IDX_SH = `FX_FRAC_BITS + TILE_SHIFT;

  localparam logic signed [W-1:0] MAX_TX_S = W'(MAX_TILE_X);
  localparam logic signed [W-1:0] MAX_TY_S = W'(MAX_TILE_Y);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BBOX  = 2'd1;
  localparam logic [1:0] CLAMP = 2'd2;
  localparam logic [1:0] ISSUE = 2'd3;

  logic [1:0]          state_reg;
  coord_3d_t           v0_reg, v1_reg, v2_reg;
  // tile_x/tile_y of the latched metadata double as the current-tile cursor
  metadata_t           meta_reg;
  logic signed [W-1:0] min_x_reg, max_x_reg, min_y_reg, max_y_reg;
  logic [CW-1:0]       min_tx_reg, max_tx_reg;
  logic [RW-1:0]       max_ty_reg;
  logic                rdy_in_reg, vld_out_reg, tri_done_reg, tri_culled_reg;
  logic [CNT_W-1:0]    tile_count_reg;

  function automatic logic signed [W-1:0] min3(input logic signed [W-1:0] a, b, c);
    logic signed [W-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [W-1:0] max3(input logic signed [W-1:0] a, b, c);
    logic signed [W-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  // Arithmetic shift floors toward -inf, so a vertex at -1 px lands in tile -1.
  logic signed [W-1:0] min_tx_s, max_tx_s, min_ty_s, max_ty_s;
  logic                cull;
  logic [CW-1:0]       clamp_min_tx, clamp_max_tx;
  logic [RW-1:0]       clamp_min_ty, clamp_max_ty;

  always_comb begin
    min_tx_s = min_x_reg >>> IDX_SH;
    max_tx_s = max_x_reg >>> IDX_SH;
    min_ty_s = min_y_reg >>> IDX_SH;
    max_ty_s = max_y_reg >>> IDX_SH;
    cull = max_tx_s[W-1] || max_ty_s[W-1] || (min_tx_s > MAX_TX_S) || (min_ty_s > MAX_TY_S);
    // Slicing is safe only for the non-culled case, where values are in range.
    clamp_min_tx = min_tx_s[W-1] ? '0 : min_tx_s[CW-1:0];
    clamp_min_ty = min_ty_s[W-1] ? '0 : min_ty_s[RW-1:0];
    clamp_max_tx = (max_tx_s > MAX_TX_S) ? CW'(MAX_TILE_X) : max_tx_s[CW-1:0];
    clamp_max_ty = (max_ty_s > MAX_TY_S) ? RW'(MAX_TILE_Y) : max_ty_s[RW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      v0_reg         <= '0;
      v1_reg         <= '0;
      v2_reg         <= '0;
      meta_reg       <= '0;
      min_x_reg      <= '0;
      max_x_reg      <= '0;
      min_y_reg      <= '0;
      max_y_reg      <= '0;
      min_tx_reg     <= '0;
      max_tx_reg     <= '0;
      max_ty_reg     <= '0;
      rdy_in_reg     <= 1'b1;
      vld_out_reg    <= 1'b0;
      tri_done_reg   <= 1'b0;
      tri_culled_reg <= 1'b0;
      tile_count_reg <= '0;
    end else begin
      tri_done_reg   <= 1'b0;
      tri_culled_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // rdy_in is high throughout IDLE, so vld_in alone completes the handshake
          if (vld_in) begin
            v0_reg         <= v0;
            v1_reg         <= v1;
            v2_reg         <= v2;
            meta_reg       <= in_metadata;
            tile_count_reg <= '0;
            rdy_in_reg     <= 1'b0;
            state_reg      <= BBOX;
          end
        end
        BBOX: begin
          min_x_reg <= min3(v0_reg.x, v1_reg.x, v2_reg.x);
          max_x_reg <= max3(v0_reg.x, v1_reg.x, v2_reg.x);
          min_y_reg <= min3(v0_reg.y, v1_reg.y, v2_reg.y);
          max_y_reg <= max3(v0_reg.y, v1_reg.y, v2_reg.y);
          state_reg <= CLAMP;
        end
        CLAMP: begin
          if (cull) begin
            tri_done_reg   <= 1'b1;
            tri_culled_reg <= 1'b1;
            rdy_in_reg     <= 1'b1;
            state_reg      <= IDLE;
          end else begin
            min_tx_reg      <= clamp_min_tx;
            max_tx_reg      <= clamp_max_tx;
            max_ty_reg      <= clamp_max_ty;
            meta_reg.tile_x <= clamp_min_tx;
            meta_reg.tile_y <= clamp_min_ty;
            vld_out_reg     <= 1'b1;
            state_reg       <= ISSUE;
          end
        end
        ISSUE: begin
          if (rdy_out) begin
            if (tile_count_reg != '1) begin
              tile_count_reg <= tile_count_reg + 1'b1;
            end
            if (meta_reg.tile_x == max_tx_reg) begin
              if (meta_reg.tile_y == max_ty_reg) begin
                vld_out_reg  <= 1'b0;
                tri_done_reg <= 1'b1;
                rdy_in_reg   <= 1'b1;
                state_reg    <= IDLE;
              end else begin
                meta_reg.tile_x <= min_tx_reg;
                meta_reg.tile_y <= meta_reg.tile_y + 1'b1;
              end
            end else begin
              meta_reg.tile_x <= meta_reg.tile_x + 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rdy_in       = rdy_in_reg;
  assign vld_out      = vld_out_reg;
  assign out_v0       = v0_reg;
  assign out_v1       = v1_reg;
  assign out_v2       = v2_reg;
  assign out_metadata = meta_reg;
  assign tri_done     = tri_done_reg;
  assign tri_culled   = tri_culled_reg;
  assign tile_count   = tile_count_reg;

endmodule

// File: tb/tb_tile_dispatcher.sv
// tb_tile_dispatcher
//   Directed and randomized triangles checked against a tile-list reference
//   model computed with integer floor division over the pixel grid.
module tb_tile_dispatcher;
  import tile_dispatcher_pkg::*;

  localparam int FXS      = 1 << `FX_FRAC_BITS;
  localparam int TILE_FX  = FXS * 32;
  localparam int MAXT_X   = (1 << `TILE_COLUMNS_BITS) - 1;
  localparam int MAXT_Y   = (1 << `TILE_ROWS_BITS) - 1;
  localparam int BUDGET   = 3000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vld_in = 1'b0;
  logic        rdy_out = 1'b0;
  logic        rdy_in, vld_out, tri_done, tri_culled;
  logic [15:0] tile_count;
  coord_3d_t   v0 = '0, v1 = '0, v2 = '0;
  coord_3d_t   out_v0, out_v1, out_v2;
  metadata_t   in_metadata = '0;
  metadata_t   out_metadata;

  int n_cmp = 0;
  int n_fail = 0;
  int exp_x[$];
  int exp_y[$];
  bit exp_culled;

  always #5 clk = ~clk;

  tile_dispatcher dut (
    .clk(clk), .rst_n(rst_n), .vld_in(vld_in), .rdy_in(rdy_in),
    .v0(v0), .v1(v1), .v2(v2), .in_metadata(in_metadata),
    .rdy_out(rdy_out), .vld_out(vld_out),
    .out_v0(out_v0), .out_v1(out_v1), .out_v2(out_v2),
    .out_metadata(out_metadata), .tri_done(tri_done), .tri_culled(tri_culled),
    .tile_count(tile_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic coord_3d_t pt(input int px, input int py);
    coord_3d_t c;
    c.x = 16'(px * FXS);
    c.y = 16'(py * FXS);
    c.z = 16'($urandom);
    return c;
  endfunction

  function automatic int fdiv(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Reference: covered tile set from the bounding box, on-screen portion only.
  task automatic model(input coord_3d_t a, input coord_3d_t b, input coord_3d_t c);
    int xs[3];
    int ys[3];
    int mnx, mxx, mny, mxy, tx0, tx1, ty0, ty1;
    xs[0] = int'(a.x); xs[1] = int'(b.x); xs[2] = int'(c.x);
    ys[0] = int'(a.y); ys[1] = int'(b.y); ys[2] = int'(c.y);
    mnx = xs[0]; mxx = xs[0]; mny = ys[0]; mxy = ys[0];
    for (int i = 1; i < 3; i++) begin
      if (xs[i] < mnx) mnx = xs[i];
      if (xs[i] > mxx) mxx = xs[i];
      if (ys[i] < mny) mny = ys[i];
      if (ys[i] > mxy) mxy = ys[i];
    end
    tx0 = fdiv(mnx, TILE_FX); tx1 = fdiv(mxx, TILE_FX);
    ty0 = fdiv(mny, TILE_FX); ty1 = fdiv(mxy, TILE_FX);
    exp_x.delete();
    exp_y.delete();
    exp_culled = (tx1 < 0) || (ty1 < 0) || (tx0 > MAXT_X) || (ty0 > MAXT_Y);
    if (!exp_culled) begin
      if (tx0 < 0) tx0 = 0;
      if (ty0 < 0) ty0 = 0;
      if (tx1 > MAXT_X) tx1 = MAXT_X;
      if (ty1 > MAXT_Y) ty1 = MAXT_Y;
      for (int y = ty0; y <= ty1; y++)
        for (int x = tx0; x <= tx1; x++) begin
          exp_x.push_back(x);
          exp_y.push_back(y);
        end
    end
  endtask

  task automatic run_tri(input coord_3d_t a, input coord_3d_t b, input coord_3d_t c,
                         input metadata_t md, input int pct, input int stall_tile,
                         input int stall_cyc, input bit pulse);
    int n, idx, stall_cnt, total;
    bit done, prev_hold;
    metadata_t prev_meta;
    model(a, b, c);
    total = exp_x.size();
    @(negedge clk);
    check("idle_rdy_in", 64'(rdy_in), 64'd1);
    check("idle_tri_done", 64'(tri_done), 64'd0);
    check("idle_vld_out", 64'(vld_out), 64'd0);
    v0 = a; v1 = b; v2 = c; in_metadata = md; vld_in = 1'b1; rdy_out = 1'b0;
    @(posedge clk);
    n = 1; idx = 0; stall_cnt = 0; done = 1'b0; prev_hold = 1'b0; prev_meta = '0;
    while (!done && n < BUDGET) begin
      @(negedge clk);
      if (pulse && n == 5) begin
        vld_in = 1'b1;
        v0 = pt(7, 7);
      end else begin
        vld_in = 1'b0;
      end
      if (n < 3) begin
        check("lat_vld_out", 64'(vld_out), 64'd0);
        check("lat_rdy_in", 64'(rdy_in), 64'd0);
        check("lat_tri_done", 64'(tri_done), 64'd0);
      end else if (exp_culled) begin
        check("cull_tri_done", 64'(tri_done), 64'd1);
        check("cull_tri_culled", 64'(tri_culled), 64'd1);
        check("cull_rdy_in", 64'(rdy_in), 64'd1);
        check("cull_vld_out", 64'(vld_out), 64'd0);
        check("cull_tile_count", 64'(tile_count), 64'd0);
        done = 1'b1;
      end else begin
        check("vld_out", 64'(vld_out), 64'(idx < total));
        check("tri_done", 64'(tri_done), 64'(idx == total));
        check("tri_culled", 64'(tri_culled), 64'd0);
        check("tile_count", 64'(tile_count), 64'(idx));
        if (prev_hold) check("hold_meta", 64'(out_metadata), 64'(prev_meta));
        if (idx == total) begin
          check("done_rdy_in", 64'(rdy_in), 64'd1);
          done = 1'b1;
        end else begin
          check("issue_rdy_in", 64'(rdy_in), 64'd0);
          check("tile_x", 64'(out_metadata.tile_x), 64'(exp_x[idx]));
          check("tile_y", 64'(out_metadata.tile_y), 64'(exp_y[idx]));
          check("tri_id", 64'(out_metadata.tri_id), 64'(md.tri_id));
          check("out_v0", 64'(out_v0), 64'(a));
          check("out_v1", 64'(out_v1), 64'(b));
          check("out_v2", 64'(out_v2), 64'(c));
        end
      end
      if (!done) begin
        rdy_out = ($urandom_range(99) < pct);
        if (idx == stall_tile && stall_cnt < stall_cyc) begin
          rdy_out = 1'b0;
          stall_cnt++;
        end
        prev_hold = vld_out && !rdy_out;
        prev_meta = out_metadata;
        if (vld_out && rdy_out) idx++;
        @(posedge clk);
        n++;
      end
    end
    if (!done) check("timeout", 64'd0, 64'd1);
    vld_in = 1'b0;
    rdy_out = 1'b0;
    $display("tri id=%0h tiles=%0d culled=%0d cycles=%0d", md.tri_id, total, exp_culled, n);
  endtask

  initial begin
    int cx, cy;
    coord_3d_t a, b, c;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rdy_in", 64'(rdy_in), 64'd1);
    check("rst_vld_out", 64'(vld_out), 64'd0);
    check("rst_tri_done", 64'(tri_done), 64'd0);
    check("rst_tri_culled", 64'(tri_culled), 64'd0);
    check("rst_tile_count", 64'(tile_count), 64'd0);
    check("rst_out_v0", 64'(out_v0), 64'd0);
    check("rst_out_meta", 64'(out_metadata), 64'd0);
    rst_n = 1'b1;

    // Single tile
    run_tri(pt(10, 10), pt(20, 10), pt(10, 20), metadata_t'($urandom), 100, -1, 0, 1'b0);
    // 3x2 tiles, back-to-back
    run_tri(pt(10, 10), pt(70, 25), pt(40, 40), metadata_t'($urandom), 100, -1, 0, 1'b0);
    // Off-screen left, above, and right
    run_tri(pt(-100, 5), pt(-40, 50), pt(-70, 100), metadata_t'($urandom), 100, -1, 0, 1'b0);
    run_tri(pt(10, -90), pt(60, -30), pt(30, -5), metadata_t'($urandom), 100, -1, 0, 1'b0);
    run_tri(pt(1100, 5), pt(1200, 50), pt(1150, 20), metadata_t'($urandom), 100, -1, 0, 1'b0);
    // Clamp at left and right screen edges
    run_tri(pt(-50, 0), pt(40, 5), pt(0, 10), metadata_t'($urandom), 100, -1, 0, 1'b0);
    run_tri(pt(950, 0), pt(1100, 5), pt(1000, 10), metadata_t'($urandom), 100, -1, 0, 1'b0);
    // Stall on the fourth tile plus an ignored vld_in pulse
    run_tri(pt(10, 10), pt(70, 25), pt(40, 40), metadata_t'($urandom), 100, 3, 5, 1'b1);

    // Asynchronous reset mid-ISSUE
    @(negedge clk);
    v0 = pt(10, 10); v1 = pt(70, 25); v2 = pt(40, 40);
    in_metadata = metadata_t'($urandom);
    vld_in = 1'b1;
    @(negedge clk);
    vld_in = 1'b0;
    rdy_out = 1'b1;
    for (int i = 0; i < 10 && !vld_out; i++) @(negedge clk);
    check("pre_rst_vld_out", 64'(vld_out), 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_vld_out", 64'(vld_out), 64'd0);
    check("arst_rdy_in", 64'(rdy_in), 64'd1);
    check("arst_tri_done", 64'(tri_done), 64'd0);
    check("arst_tile_count", 64'(tile_count), 64'd0);
    @(negedge clk);
    check("arst_no_done", 64'(tri_done), 64'd0);
    rdy_out = 1'b0;
    rst_n = 1'b1;
    $display("reset mid-issue applied");
    run_tri(pt(10, 10), pt(70, 25), pt(40, 40), metadata_t'($urandom), 100, -1, 0, 1'b0);

    // Randomized triangles, some partly or fully off-screen
    for (int t = 0; t < 25; t++) begin
      cx = $urandom_range(1600) - 300;
      cy = $urandom_range(1600) - 300;
      a = pt(cx + $urandom_range(200) - 100, cy + $urandom_range(200) - 100);
      b = pt(cx + $urandom_range(200) - 100, cy + $urandom_range(200) - 100);
      c = pt(cx + $urandom_range(200) - 100, cy + $urandom_range(200) - 100);
      run_tri(a, b, c, metadata_t'($urandom), 30 + $urandom_range(70), -1, 0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
